// File: rtl/audio_mem_arbiter_if.sv
// Bundle of the arbiter's request/ack and memory-port signals.
//   slave  : arbiter view (requests, busy flags and read data in; acks, strobes and addresses out)
//   master : environment view (requesters, memories, video busy sources)
// Signal groups:
//   vram_busy_i / tile_busy_i   video owns the memory this cycle
//   aud_*                       audio DMA fetch port (read only)
//   host_*                      host register/CPU port (read/write)
//   vram_* / tile_*             memory ports, read data valid one cycle after sel
interface audio_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              vram_busy_i;
  logic              tile_busy_i;

  logic              aud_req_i;
  logic              aud_tile_i;
  logic [ADDR_W-1:0] aud_addr_i;
  logic              aud_ack_o;
  logic [DATA_W-1:0] aud_word_o;

  logic              host_req_i;
  logic              host_tile_i;
  logic              host_wr_i;
  logic [ADDR_W-1:0] host_addr_i;
  logic [DATA_W-1:0] host_data_i;
  logic              host_ack_o;
  logic [DATA_W-1:0] host_data_o;

  logic              vram_sel_o;
  logic              vram_wr_o;
  logic [ADDR_W-1:0] vram_addr_o;
  logic [DATA_W-1:0] vram_data_o;
  logic [DATA_W-1:0] vram_data_i;

  logic              tile_sel_o;
  logic              tile_wr_o;
  logic [ADDR_W-1:0] tile_addr_o;
  logic [DATA_W-1:0] tile_data_o;
  logic [DATA_W-1:0] tile_data_i;

  modport slave (
    input  vram_busy_i, tile_busy_i,
    input  aud_req_i, aud_tile_i, aud_addr_i,
    output aud_ack_o, aud_word_o,
    input  host_req_i, host_tile_i, host_wr_i, host_addr_i, host_data_i,
    output host_ack_o, host_data_o,
    output vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o,
    input  vram_data_i,
    output tile_sel_o, tile_wr_o, tile_addr_o, tile_data_o,
    input  tile_data_i
  );

  modport master (
    output vram_busy_i, tile_busy_i,
    output aud_req_i, aud_tile_i, aud_addr_i,
    input  aud_ack_o, aud_word_o,
    output host_req_i, host_tile_i, host_wr_i, host_addr_i, host_data_i,
    input  host_ack_o, host_data_o,
    input  vram_sel_o, vram_wr_o, vram_addr_o, vram_data_o,
    output vram_data_i,
    input  tile_sel_o, tile_wr_o, tile_addr_o, tile_data_o,
    output tile_data_i
  );
endinterface

// File: rtl/audio_mem_arbiter.sv
// Shares the VRAM and TILE memory ports between the audio DMA fetch port and the host port.
// Video has absolute priority through the per-memory busy flags; host beats audio unless
// audio has waited STARVE_LIM idle cycles, after which only audio may be granted.
// One transfer in flight: IDLE (grant, drive memory) -> XFER (capture read data) -> ACK.
// Ports:
//   clk      system clock
//   reset_i  asynchronous active-high reset; abandons any transfer without an ack
//   bus      audio_mem_arbiter_if.slave (requests, acks, memory ports)
module audio_mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned STARVE_LIM = 8
) (
  input logic                clk,
  input logic                reset_i,
  audio_mem_arbiter_if.slave bus
);

  // Keep the counter at least one bit wide so STARVE_LIM = 0 still elaborates.
  localparam int unsigned     CntW   = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIM);

  typedef enum logic [1:0] {StIdle, StXfer, StAck} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   wait_cnt_q, wait_cnt_d;
  logic              win_host_q, win_host_d;
  logic              tgt_tile_q, tgt_tile_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] aud_word_q, aud_word_d;
  logic [DATA_W-1:0] host_data_q, host_data_d;
  logic [ADDR_W-1:0] vram_addr_q, tile_addr_q;
  logic [DATA_W-1:0] vram_data_q, tile_data_q;

  logic              a_ok, h_ok, starved;
  logic              gnt_aud, gnt_host, gnt_any, gnt_tile, gnt_wr;
  logic [ADDR_W-1:0] gnt_addr;
  logic              vram_sel, tile_sel;
  logic [ADDR_W-1:0] vram_addr, tile_addr;
  logic [DATA_W-1:0] vram_data, tile_data;
  logic [DATA_W-1:0] rd_word;

  // Grant decision, only meaningful in IDLE. Gated by reset so the memory strobes
  // drop the moment reset is asserted, even with a request still pending.
  always_comb begin
    a_ok     = bus.aud_req_i && !(bus.aud_tile_i ? bus.tile_busy_i : bus.vram_busy_i);
    h_ok     = bus.host_req_i && !(bus.host_tile_i ? bus.tile_busy_i : bus.vram_busy_i);
    starved  = (wait_cnt_q == CntMax) && bus.aud_req_i;
    gnt_aud  = 1'b0;
    gnt_host = 1'b0;
    if (state_q == StIdle && !reset_i) begin
      if (starved) begin
        gnt_aud = a_ok;
      end else if (h_ok) begin
        gnt_host = 1'b1;
      end else begin
        gnt_aud = a_ok;
      end
    end
    gnt_any  = gnt_aud || gnt_host;
    gnt_tile = gnt_aud ? bus.aud_tile_i : bus.host_tile_i;
    gnt_wr   = gnt_host && bus.host_wr_i;
    gnt_addr = gnt_aud ? bus.aud_addr_i : bus.host_addr_i;
  end

  // Memory ports: strobes only in the grant cycle; address/data hold their last value otherwise.
  always_comb begin
    vram_sel  = gnt_any && !gnt_tile;
    tile_sel  = gnt_any && gnt_tile;
    vram_addr = vram_sel ? gnt_addr : vram_addr_q;
    tile_addr = tile_sel ? gnt_addr : tile_addr_q;
    vram_data = (vram_sel && gnt_wr) ? bus.host_data_i : vram_data_q;
    tile_data = (tile_sel && gnt_wr) ? bus.host_data_i : tile_data_q;
  end

  assign bus.vram_sel_o  = vram_sel;
  assign bus.vram_wr_o   = vram_sel && gnt_wr;
  assign bus.vram_addr_o = vram_addr;
  assign bus.vram_data_o = vram_data;
  assign bus.tile_sel_o  = tile_sel;
  assign bus.tile_wr_o   = tile_sel && gnt_wr;
  assign bus.tile_addr_o = tile_addr;
  assign bus.tile_data_o = tile_data;

  assign bus.aud_ack_o   = (state_q == StAck) && !win_host_q;
  assign bus.host_ack_o  = (state_q == StAck) && win_host_q;
  assign bus.aud_word_o  = aud_word_q;
  assign bus.host_data_o = host_data_q;

  always_comb begin
    state_d     = state_q;
    win_host_d  = win_host_q;
    tgt_tile_d  = tgt_tile_q;
    wr_d        = wr_q;
    aud_word_d  = aud_word_q;
    host_data_d = host_data_q;
    wait_cnt_d  = wait_cnt_q;
    rd_word     = tgt_tile_q ? bus.tile_data_i : bus.vram_data_i;

    case (state_q)
      StIdle: begin
        if (gnt_any) begin
          state_d    = StXfer;
          win_host_d = gnt_host;
          tgt_tile_d = gnt_tile;
          wr_d       = gnt_wr;
        end
      end
      StXfer: begin
        if (!wr_q) begin
          if (win_host_q) begin
            host_data_d = rd_word;
          end else begin
            aud_word_d = rd_word;
          end
        end
        state_d = StAck;
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Audio wait counter: counts only idle cycles spent losing, holds during a transfer.
    if (!bus.aud_req_i || gnt_aud) begin
      wait_cnt_d = '0;
    end else if (state_q == StIdle && wait_cnt_q != CntMax) begin
      wait_cnt_d = wait_cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      wait_cnt_q  <= '0;
      win_host_q  <= 1'b0;
      tgt_tile_q  <= 1'b0;
      wr_q        <= 1'b0;
      aud_word_q  <= '0;
      host_data_q <= '0;
      vram_addr_q <= '0;
      tile_addr_q <= '0;
      vram_data_q <= '0;
      tile_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      win_host_q  <= win_host_d;
      tgt_tile_q  <= tgt_tile_d;
      wr_q        <= wr_d;
      aud_word_q  <= aud_word_d;
      host_data_q <= host_data_d;
      vram_addr_q <= vram_addr;
      tile_addr_q <= tile_addr;
      vram_data_q <= vram_data;
      tile_data_q <= tile_data;
    end
  end

endmodule

// File: tb/tb_audio_mem_arbiter.sv
// Bench for audio_mem_arbiter: one instance with STARVE_LIM = 8 fed by a table of grant
// vectors and hand-written multi-cycle sequences, plus one with STARVE_LIM = 0.
// Read data comes from a memory model returning addr ^ key; acks are matched against a
// scoreboard of expected winners and read words.
module tb_audio_mem_arbiter;

  localparam logic [15:0] VKEY = 16'hB76E;  // VRAM word at 0x1234 reads as 0xA55A
  localparam logic [15:0] TKEY = 16'h3C3C;

  logic clk = 1'b0;
  logic rst8;
  logic rst0;
  always #5 clk = ~clk;

  audio_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b8 ();
  audio_mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) b0 ();

  audio_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIM(8)) dut8 (
    .clk(clk), .reset_i(rst8), .bus(b8)
  );
  audio_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIM(0)) dut0 (
    .clk(clk), .reset_i(rst0), .bus(b0)
  );

  int checks = 0;
  int errors = 0;

  function automatic void chk_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endfunction

  function automatic void chk_word(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Memory model for the STARVE_LIM = 8 instance
  logic [15:0] wr_addr, wr_data;
  always @(posedge clk) begin
    if (b8.vram_sel_o && !b8.vram_wr_o) b8.vram_data_i <= b8.vram_addr_o ^ VKEY;
    if (b8.tile_sel_o && !b8.tile_wr_o) b8.tile_data_i <= b8.tile_addr_o ^ TKEY;
    if (b8.tile_sel_o && b8.tile_wr_o) begin
      wr_addr <= b8.tile_addr_o;
      wr_data <= b8.tile_data_o;
    end
  end

  // Scoreboard of expected acks
  typedef struct {
    logic        host;
    logic        chk_data;
    logic [15:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  function automatic void push_exp(logic host, logic chk_data, logic [15:0] data);
    exp_t e;
    e.host     = host;
    e.chk_data = chk_data;
    e.data     = data;
    sb.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (!rst8 && (b8.aud_ack_o || b8.host_ack_o)) begin
      if (sb.size() == 0) begin
        chk_bit("unexpected ack", 1'b1, 1'b0);
      end else begin
        mon_e = sb.pop_front();
        chk_bit("sb ack owner", b8.host_ack_o, mon_e.host);
        chk_bit("sb single ack", b8.aud_ack_o && b8.host_ack_o, 1'b0);
        if (mon_e.chk_data) begin
          chk_word("sb read word", mon_e.host ? b8.host_data_o : b8.aud_word_o, mon_e.data);
        end
      end
    end
  end

  // Grant vector table: applied in the first idle cycle after reset (wait counter at 0).
  typedef struct {
    logic        a_req, a_tile;
    logic [15:0] a_addr;
    logic        h_req, h_tile, h_wr;
    logic [15:0] h_addr, h_data;
    logic        vbusy, tbusy;
    logic        e_vsel, e_tsel, e_wr;
    logic [15:0] e_addr;
    logic        e_host;
  } vec_t;
  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic drop8();
    b8.aud_req_i   = 1'b0;
    b8.host_req_i  = 1'b0;
    b8.host_wr_i   = 1'b0;
    b8.vram_busy_i = 1'b0;
    b8.tile_busy_i = 1'b0;
  endtask

  task automatic reset8();
    rst8 = 1'b1;
    drop8();
    @(posedge clk);
    #1 rst8 = 1'b0;
  endtask

  task automatic drive8(input vec_t v);
    b8.aud_req_i   = v.a_req;
    b8.aud_tile_i  = v.a_tile;
    b8.aud_addr_i  = v.a_addr;
    b8.host_req_i  = v.h_req;
    b8.host_tile_i = v.h_tile;
    b8.host_wr_i   = v.h_wr;
    b8.host_addr_i = v.h_addr;
    b8.host_data_i = v.h_data;
    b8.vram_busy_i = v.vbusy;
    b8.tile_busy_i = v.tbusy;
  endtask

  // Called in the grant cycle; checks XFER and ACK, then drops requests in the next IDLE.
  task automatic finish_xfer(input logic host, input logic busy_flip);
    @(posedge clk);
    #2;
    if (busy_flip) begin
      b8.vram_busy_i = 1'b1;
      b8.tile_busy_i = 1'b1;
    end
    #1;
    chk_bit("xfer no ack", b8.aud_ack_o || b8.host_ack_o, 1'b0);
    chk_bit("xfer no sel", b8.vram_sel_o || b8.tile_sel_o, 1'b0);
    @(posedge clk);
    #2;
    chk_bit("ack host", b8.host_ack_o, host);
    chk_bit("ack aud", b8.aud_ack_o, !host);
    @(posedge clk);
    #1 drop8();
  endtask

  // Waits (bounded) for the next grant, reporting which memory; leaves time in the XFER cycle.
  task automatic next_grant(output logic got, output logic tile);
    got  = 1'b0;
    tile = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      if (b8.vram_sel_o || b8.tile_sel_o) begin
        got  = 1'b1;
        tile = b8.tile_sel_o;
      end
      @(posedge clk);
      #3;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic got, tile;

    vecs[0] = '{1, 0, 16'h1234, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h1234, 0};
    vecs[1] = '{1, 1, 16'h0ABC, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, 0, 16'h0ABC, 0};
    vecs[2] = '{0, 0, 16'h0000, 1, 0, 0, 16'h2000, 16'h0000, 0, 0, 1, 0, 0, 16'h2000, 1};
    vecs[3] = '{0, 0, 16'h0000, 1, 1, 1, 16'h0041, 16'hCAFE, 0, 0, 0, 1, 1, 16'h0041, 1};
    vecs[4] = '{1, 1, 16'h0011, 1, 0, 0, 16'h0022, 16'h0000, 0, 0, 1, 0, 0, 16'h0022, 1};
    vecs[5] = '{1, 1, 16'h0011, 1, 0, 0, 16'h0022, 16'h0000, 1, 0, 0, 1, 0, 16'h0011, 0};
    vecs[6] = '{1, 0, 16'h0011, 1, 0, 0, 16'h0022, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 0};
    vecs[7] = '{1, 0, 16'h0033, 1, 1, 0, 16'h0044, 16'h0000, 0, 1, 1, 0, 0, 16'h0033, 0};
    vecs[8] = '{0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 0};
    vecs[9] = '{1, 0, 16'h0055, 1, 1, 1, 16'h0066, 16'h1357, 1, 0, 0, 1, 1, 16'h0066, 1};

    rst8 = 1'b1;
    rst0 = 1'b1;
    drop8();
    b8.aud_tile_i  = 1'b0;
    b8.aud_addr_i  = 16'h0;
    b8.host_tile_i = 1'b0;
    b8.host_addr_i = 16'h0;
    b8.host_data_i = 16'h0;
    b0.aud_req_i   = 1'b0;
    b0.aud_tile_i  = 1'b0;
    b0.aud_addr_i  = 16'h0;
    b0.host_req_i  = 1'b0;
    b0.host_tile_i = 1'b0;
    b0.host_wr_i   = 1'b0;
    b0.host_addr_i = 16'h0;
    b0.host_data_i = 16'h0;
    b0.vram_busy_i = 1'b0;
    b0.tile_busy_i = 1'b0;
    b0.vram_data_i = 16'h1111;
    b0.tile_data_i = 16'h2222;

    // Reset state
    #1;
    chk_bit("rst acks", b8.aud_ack_o || b8.host_ack_o, 1'b0);
    chk_bit("rst sels", b8.vram_sel_o || b8.tile_sel_o, 1'b0);
    chk_bit("rst wrs", b8.vram_wr_o || b8.tile_wr_o, 1'b0);
    chk_word("rst vram_addr", b8.vram_addr_o, 16'h0);
    chk_word("rst tile_addr", b8.tile_addr_o, 16'h0);
    chk_word("rst vram_data", b8.vram_data_o, 16'h0);
    chk_word("rst tile_data", b8.tile_data_o, 16'h0);
    chk_word("rst aud_word", b8.aud_word_o, 16'h0);
    chk_word("rst host_data", b8.host_data_o, 16'h0);
    @(posedge clk);
    #1 rst0 = 1'b0;

    // Table-driven single grants
    for (int i = 0; i < NV; i++) begin
      reset8();
      drive8(vecs[i]);
      #1;
      chk_bit($sformatf("v%0d vram_sel", i), b8.vram_sel_o, vecs[i].e_vsel);
      chk_bit($sformatf("v%0d tile_sel", i), b8.tile_sel_o, vecs[i].e_tsel);
      chk_bit($sformatf("v%0d wr", i), b8.vram_wr_o || b8.tile_wr_o, vecs[i].e_wr);
      if (vecs[i].e_vsel || vecs[i].e_tsel) begin
        chk_word($sformatf("v%0d addr", i),
                 vecs[i].e_tsel ? b8.tile_addr_o : b8.vram_addr_o, vecs[i].e_addr);
        push_exp(vecs[i].e_host, !vecs[i].e_wr,
                 vecs[i].e_addr ^ (vecs[i].e_tsel ? TKEY : VKEY));
        finish_xfer(vecs[i].e_host, 1'b0);
      end else begin
        drop8();
      end
    end

    // Host write to TILE held off by video for three cycles; busy rises again mid-transfer
    reset8();
    b8.tile_busy_i = 1'b1;
    b8.host_req_i  = 1'b1;
    b8.host_tile_i = 1'b1;
    b8.host_wr_i   = 1'b1;
    b8.host_addr_i = 16'h0040;
    b8.host_data_i = 16'hBEEF;
    for (int k = 0; k < 3; k++) begin
      #1 chk_bit("busy hold tile_sel", b8.tile_sel_o, 1'b0);
      @(posedge clk);
      #1;
    end
    b8.tile_busy_i = 1'b0;
    #1;
    chk_bit("wr tile_sel", b8.tile_sel_o, 1'b1);
    chk_bit("wr tile_wr", b8.tile_wr_o, 1'b1);
    chk_word("wr tile_addr", b8.tile_addr_o, 16'h0040);
    chk_word("wr tile_data", b8.tile_data_o, 16'hBEEF);
    chk_bit("wr vram_sel", b8.vram_sel_o, 1'b0);
    push_exp(1'b1, 1'b0, 16'h0);
    finish_xfer(1'b1, 1'b1);
    chk_word("wr mem addr", wr_addr, 16'h0040);
    chk_word("wr mem data", wr_data, 16'hBEEF);
    chk_word("wr addr held", b8.tile_addr_o, 16'h0040);

    // Both held: eight host grants, then audio, then host again (counter cleared)
    reset8();
    b8.host_req_i  = 1'b1;
    b8.host_tile_i = 1'b0;
    b8.host_addr_i = 16'h0100;
    b8.aud_req_i   = 1'b1;
    b8.aud_tile_i  = 1'b1;
    b8.aud_addr_i  = 16'h0200;
    for (int g = 0; g < 10; g++) begin
      push_exp(g != 8, 1'b1, (g != 8) ? (16'h0100 ^ VKEY) : (16'h0200 ^ TKEY));
    end
    #2;
    for (int g = 0; g < 10; g++) begin
      next_grant(got, tile);
      chk_bit($sformatf("starve g%0d granted", g), got, 1'b1);
      chk_bit($sformatf("starve g%0d audio", g), tile, g == 8);
    end
    @(posedge clk);
    @(posedge clk);
    #1 drop8();

    // Starved audio blocked by video: host not granted either until VRAM frees
    reset8();
    b8.host_req_i  = 1'b1;
    b8.host_tile_i = 1'b1;
    b8.host_addr_i = 16'h0010;
    b8.aud_req_i   = 1'b1;
    b8.aud_tile_i  = 1'b0;
    b8.aud_addr_i  = 16'h0020;
    b8.vram_busy_i = 1'b1;
    for (int g = 0; g < 8; g++) push_exp(1'b1, 1'b1, 16'h0010 ^ TKEY);
    push_exp(1'b0, 1'b1, 16'h0020 ^ VKEY);
    #2;
    for (int g = 0; g < 8; g++) begin
      next_grant(got, tile);
      chk_bit($sformatf("blk g%0d granted", g), got, 1'b1);
      chk_bit($sformatf("blk g%0d host tile", g), tile, 1'b1);
    end
    @(posedge clk);
    #3;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #3 chk_bit("blk starved no grant", b8.vram_sel_o || b8.tile_sel_o, 1'b0);
    end
    b8.vram_busy_i = 1'b0;
    #1;
    chk_bit("blk audio vram_sel", b8.vram_sel_o, 1'b1);
    chk_bit("blk audio tile_sel", b8.tile_sel_o, 1'b0);
    chk_word("blk audio addr", b8.vram_addr_o, 16'h0020);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 drop8();

    // Asynchronous reset during XFER of a host read
    reset8();
    b8.host_req_i  = 1'b1;
    b8.host_tile_i = 1'b0;
    b8.host_addr_i = 16'h0300;
    #1 chk_bit("pre rst vram_sel", b8.vram_sel_o, 1'b1);
    push_exp(1'b1, 1'b1, 16'h0300 ^ VKEY);
    finish_xfer(1'b1, 1'b0);
    b8.host_req_i  = 1'b1;
    b8.host_addr_i = 16'h0700;
    #1 chk_bit("abort vram_sel", b8.vram_sel_o, 1'b1);
    @(posedge clk);
    #2 rst8 = 1'b1;
    #1;
    chk_bit("arst acks", b8.aud_ack_o || b8.host_ack_o, 1'b0);
    chk_bit("arst sels", b8.vram_sel_o || b8.tile_sel_o, 1'b0);
    chk_word("arst vram_addr", b8.vram_addr_o, 16'h0);
    chk_word("arst host_data", b8.host_data_o, 16'h0);
    b8.host_req_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #2 chk_bit("post rst no ack", b8.aud_ack_o || b8.host_ack_o, 1'b0);
    end
    b8.host_req_i  = 1'b1;
    b8.host_tile_i = 1'b1;
    b8.host_addr_i = 16'h0456;
    #1 chk_bit("post rst tile_sel", b8.tile_sel_o, 1'b1);
    push_exp(1'b1, 1'b1, 16'h0456 ^ TKEY);
    finish_xfer(1'b1, 1'b0);

    // STARVE_LIM = 0: audio wins every contested grant
    @(posedge clk);
    #1;
    b0.host_req_i  = 1'b1;
    b0.host_tile_i = 1'b0;
    b0.host_addr_i = 16'h0001;
    b0.aud_req_i   = 1'b1;
    b0.aud_tile_i  = 1'b1;
    b0.aud_addr_i  = 16'h0002;
    #1;
    chk_bit("lim0 first tile_sel", b0.tile_sel_o, 1'b1);
    chk_bit("lim0 first vram_sel", b0.vram_sel_o, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk_bit("lim0 aud ack", b0.aud_ack_o, 1'b1);
    chk_bit("lim0 no host ack", b0.host_ack_o, 1'b0);
    chk_word("lim0 aud word", b0.aud_word_o, 16'h2222);
    @(posedge clk);
    #2;
    chk_bit("lim0 second tile_sel", b0.tile_sel_o, 1'b1);
    chk_bit("lim0 second vram_sel", b0.vram_sel_o, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 chk_bit("lim0 aud ack 2", b0.aud_ack_o, 1'b1);
    @(posedge clk);
    #1 b0.aud_req_i = 1'b0;
    #1 chk_bit("lim0 host vram_sel", b0.vram_sel_o, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk_bit("lim0 host ack", b0.host_ack_o, 1'b1);
    chk_word("lim0 host data", b0.host_data_o, 16'h1111);
    @(posedge clk);
    #1 b0.host_req_i = 1'b0;

    repeat (3) @(posedge clk);
    #1 chk_word("sb drained", 16'(sb.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
